// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the instruction-fetch / data-access memory port arbiter.
//
// Contents:
//   ADDR_W, DATA_W, BE_W, STARVE_W - bus geometry and starve counter width
//   busOwner_                      - which requester owns the bus transaction
//   arbState_                      - arbiter FSM encoding
//   memReq_t / memRsp_t            - request / response payloads (one byte enable per data byte)
//   fetch_payload()                - builds the request payload of a fetch (full-word read)
package mem_port_arbiter_pkg;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int BE_W     = DATA_W / 8;
  localparam int STARVE_W = 4;

  typedef enum logic {
    OWNER_FETCH,
    OWNER_DATA
  } busOwner_;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_WAIT_GNT,
    ARB_WAIT_RSP
  } arbState_;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata;
  } memReq_t;

  typedef struct packed {
    logic [DATA_W-1:0] rdata;
  } memRsp_t;

  // Instruction fetches are always full-word reads.
  function automatic memReq_t fetch_payload(input logic [ADDR_W-1:0] addr);
    memReq_t r;
    r.we    = 1'b0;
    r.addr  = addr;
    r.be    = '1;
    r.wdata = '0;
    return r;
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch stage and the memory stage onto one single-port memory
// bus with at most one transaction outstanding.
//
// Handshake: a requester raises *Req with stable fields and holds them until
// its *Gnt pulse; the arbiter raises busReq with stable fields and holds them
// until busGnt=1 (accept); the transaction then completes on the first
// busRvalid, which is forwarded combinationally as a one-cycle *Rvalid pulse.
//
// Ports:
//   clock, resetN                                 - clock, async active-low reset
//   fetchReq/fetchAddr/fetchKill                  - fetch request, address, flush
//   fetchGnt/fetchRvalid/fetchRdata               - fetch grant, response
//   dataReq/dataWe/dataAddr/dataBe/dataWdata      - memory-stage request
//   dataGnt/dataRvalid/dataRdata                  - memory-stage grant, response
//   busReq/busWe/busAddr/busBe/busWdata           - shared memory request
//   busGnt/busRvalid/busRdata                     - shared memory accept, response
//   dbgState                                      - current arbiter FSM state
//
// Build option: FETCH_STARVE_GUARD_EN adds a counter of consecutive data
// grants; once it reaches STARVE_LIMIT a waiting fetch wins the next
// arbitration. Without it the data stage always has priority.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              resetN,
  input  logic              fetchReq,
  input  logic [ADDR_W-1:0] fetchAddr,
  input  logic              fetchKill,
  output logic              fetchGnt,
  output logic              fetchRvalid,
  output logic [DATA_W-1:0] fetchRdata,
  input  logic              dataReq,
  input  logic              dataWe,
  input  logic [ADDR_W-1:0] dataAddr,
  input  logic [BE_W-1:0]   dataBe,
  input  logic [DATA_W-1:0] dataWdata,
  output logic              dataGnt,
  output logic              dataRvalid,
  output logic [DATA_W-1:0] dataRdata,
  output logic              busReq,
  output logic              busWe,
  output logic [ADDR_W-1:0] busAddr,
  output logic [BE_W-1:0]   busBe,
  output logic [DATA_W-1:0] busWdata,
  input  logic              busGnt,
  input  logic              busRvalid,
  input  logic [DATA_W-1:0] busRdata,
  output arbState_          dbgState
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("STARVE_LIMIT must be in 1..15");
  end

  arbState_ state, state_nxt;
  busOwner_ owner, owner_nxt;
  memReq_t  bus_q, bus_nxt;
  logic     discard, discard_nxt;
  logic     fetch_gnt_nxt, data_gnt_nxt;
  logic     fetch_ok, data_ok, pick_fetch, force_fetch;
  logic     rsp_fire;
  memRsp_t  rsp;

  // A fetch being flushed in the same cycle is not a candidate.
  assign fetch_ok   = fetchReq && !fetchKill;
  assign data_ok    = dataReq;
  assign pick_fetch = fetch_ok && (!data_ok || force_fetch);

`ifdef FETCH_STARVE_GUARD_EN
  logic                gnt_evt;
  logic [STARVE_W-1:0] starve_cnt;

  assign gnt_evt     = (state == ARB_WAIT_GNT) && busGnt;
  assign force_fetch = (starve_cnt == STARVE_W'(STARVE_LIMIT));

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      starve_cnt <= '0;
    end else if (!fetchReq || (gnt_evt && owner == OWNER_FETCH)) begin
      starve_cnt <= '0;
    end else if (gnt_evt && owner == OWNER_DATA && starve_cnt != '1) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  assign force_fetch = 1'b0;
`endif

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state    <= ARB_IDLE;
      owner    <= OWNER_FETCH;
      bus_q    <= '0;
      discard  <= 1'b0;
      fetchGnt <= 1'b0;
      dataGnt  <= 1'b0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      bus_q    <= bus_nxt;
      discard  <= discard_nxt;
      fetchGnt <= fetch_gnt_nxt;
      dataGnt  <= data_gnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    owner_nxt     = owner;
    bus_nxt       = bus_q;
    discard_nxt   = discard;
    fetch_gnt_nxt = 1'b0;
    data_gnt_nxt  = 1'b0;
    unique case (state)
      ARB_IDLE: begin
        discard_nxt = 1'b0;
        if (fetch_ok || data_ok) begin
          state_nxt = ARB_WAIT_GNT;
          if (pick_fetch) begin
            owner_nxt = OWNER_FETCH;
            bus_nxt   = fetch_payload(fetchAddr);
          end else begin
            owner_nxt = OWNER_DATA;
            bus_nxt   = '{we: dataWe, addr: dataAddr, be: dataBe, wdata: dataWdata};
          end
        end
      end
      ARB_WAIT_GNT: begin
        // The bus request cannot be withdrawn, so a flush here only marks the
        // fetch for discard; the flag has no effect until the response phase.
        if (owner == OWNER_FETCH && fetchKill) discard_nxt = 1'b1;
        if (busGnt) begin
          state_nxt     = ARB_WAIT_RSP;
          fetch_gnt_nxt = (owner == OWNER_FETCH);
          data_gnt_nxt  = (owner == OWNER_DATA);
        end
      end
      ARB_WAIT_RSP: begin
        if (owner == OWNER_FETCH && fetchKill) discard_nxt = 1'b1;
        if (busRvalid) begin
          state_nxt   = ARB_IDLE;
          discard_nxt = 1'b0;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // Responses are forwarded in the cycle busRvalid arrives. A flush in that
  // same cycle also suppresses the fetch response.
  assign rsp.rdata   = busRdata;
  assign rsp_fire    = (state == ARB_WAIT_RSP) && busRvalid;
  assign fetchRvalid = rsp_fire && (owner == OWNER_FETCH) && !discard && !fetchKill;
  assign dataRvalid  = rsp_fire && (owner == OWNER_DATA);
  assign fetchRdata  = fetchRvalid ? rsp.rdata : '0;
  assign dataRdata   = dataRvalid ? rsp.rdata : '0;

  assign busReq   = (state == ARB_WAIT_GNT);
  assign busWe    = bus_q.we;
  assign busAddr  = bus_q.addr;
  assign busBe    = bus_q.be;
  assign busWdata = bus_q.wdata;
  assign dbgState = state;

endmodule
